pll_reconfig_ctrl: RTL and testbench

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

---
 rtl/pll_ctrl_pkg.sv | 32 +++
 rtl/pll_lock_sync.sv | 39 +++
 rtl/pll_reconfig_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
// Shared definitions for the rPLL reconfiguration controller:
//   - selector widths (IDSEL/FBDSEL/ODSEL = 6 bits, PSDA/DUTYDA = 4 bits)
//   - power-on phase/duty values
//   - sequencer state enum and small state-class helpers
package pll_ctrl_pkg;

    localparam int SEL_W = 6;
    localparam int PD_W  = 4;

    localparam logic [PD_W-1:0] PSDA_RST   = 4'b0000;
    localparam logic [PD_W-1:0] DUTYDA_RST = 4'b1000;

    typedef enum logic [2:0] {
        RST_HOLD  = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        LOCKED    = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    // States in which the sequencer is still working towards a lock
    function automatic logic st_busy(input pll_state_e st);
        return (st == RST_HOLD) || (st == WAIT_LOCK) || (st == SETTLE);
    endfunction

    // States in which the rPLL is held in reset
    function automatic logic st_pll_reset(input pll_state_e st);
        return (st == RST_HOLD) || (st == FAULT);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync
// Two-flop synchroniser bringing the rPLL LOCK output into the clk domain.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (both flops clear to 0)
//   lock_raw in   raw LOCK, asynchronous to clk
//   lock_s   out  synchronised LOCK
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic lock_raw,
    output logic lock_s
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next-state for the two synchroniser stages
    always_comb begin
        meta_d = lock_raw;
        sync_d = meta_q;
    end

    // Synchroniser flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign lock_s = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
// Reset/lock sequencer for an rPLL with dynamic selector reconfiguration.
// The rPLL is held in reset, released, and must show a synchronised LOCK
// for STABLE_CYCLES consecutive cycles within LOCK_TIMEOUT cycles of release.
// Each timeout retries from reset; MAX_RETRIES timeouts latch a fault.
// New selectors are accepted only when idle (LOCKED or FAULT).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cfg_valid/cfg_ready             configuration handshake
//   cfg_idsel/fbdsel/odsel/psda/dutyda   requested selectors
//   pll_reset/pll_reset_p           rPLL RESET / RESET_P
//   pll_idsel/fbdsel/odsel/psda/dutyda   registered selectors to the rPLL
//   pll_lock                        raw rPLL LOCK (asynchronous)
//   clk_ok, busy, err               status
// Build option: define PLL_LOCK_MONITOR_EN to re-run the lock sequence when
// the synchronised lock drops for 2 consecutive cycles while LOCKED.
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter logic [SEL_W-1:0] DEF_IDSEL     = 6'd59,
    parameter logic [SEL_W-1:0] DEF_FBDSEL    = 6'd55,
    parameter logic [SEL_W-1:0] DEF_ODSEL     = 6'd60,
    parameter int               RST_CYCLES    = 4,
    parameter int               LOCK_TIMEOUT  = 64,
    parameter int               STABLE_CYCLES = 8,
    parameter int               MAX_RETRIES   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SEL_W-1:0] cfg_idsel,
    input  logic [SEL_W-1:0] cfg_fbdsel,
    input  logic [SEL_W-1:0] cfg_odsel,
    input  logic [PD_W-1:0]  cfg_psda,
    input  logic [PD_W-1:0]  cfg_dutyda,
    output logic             pll_reset,
    output logic             pll_reset_p,
    output logic [SEL_W-1:0] pll_idsel,
    output logic [SEL_W-1:0] pll_fbdsel,
    output logic [SEL_W-1:0] pll_odsel,
    output logic [PD_W-1:0]  pll_psda,
    output logic [PD_W-1:0]  pll_dutyda,
    input  logic             pll_lock,
    output logic             clk_ok,
    output logic             busy,
    output logic             err
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int NW = $clog2(MAX_RETRIES + 1);

    localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
    localparam logic [RW-1:0] RST_MAX     = RW'(RST_CYCLES);
    localparam logic [RW-1:0] RST_ONE     = RW'(1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX     = TW'(LOCK_TIMEOUT);
    localparam logic [TW-1:0] TMO_ONE     = TW'(1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STABLE_ONE  = SW'(1);
    localparam logic [NW-1:0] RETRY_MAX   = NW'(MAX_RETRIES);
    localparam logic [NW-1:0] RETRY_ONE   = NW'(1);

    logic lock_s;

    pll_lock_sync u_lock_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .lock_raw (pll_lock),
        .lock_s   (lock_s)
    );

    pll_state_e       state_q,  state_d;
    logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]    timer_q,  timer_d;
    logic [SW-1:0]    stable_q, stable_d;
    logic [NW-1:0]    retry_q,  retry_d;
    logic [SEL_W-1:0] idsel_q,  idsel_d;
    logic [SEL_W-1:0] fbdsel_q, fbdsel_d;
    logic [SEL_W-1:0] odsel_q,  odsel_d;
    logic [PD_W-1:0]  psda_q,   psda_d;
    logic [PD_W-1:0]  dutyda_q, dutyda_d;
    logic             pll_reset_q, pll_reset_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             clk_ok_q,    clk_ok_d;
    logic             busy_q,      busy_d;
    logic             err_q,       err_d;

    logic             accept_s;
    logic             timeout_s;
    logic [TW-1:0]    timer_inc_s;
    logic [NW-1:0]    retry_inc_s;
    pll_state_e       timeout_state_s;

`ifdef PLL_LOCK_MONITOR_EN
    localparam logic [1:0] MON_LAST = 2'd1;
    localparam logic [1:0] MON_ONE  = 2'd1;
    logic [1:0] mon_cnt_q, mon_cnt_d;
`endif

    // Sequencer next-state, counters, selector capture and output decode
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        timer_d   = timer_q;
        stable_d  = stable_q;
        retry_d   = retry_q;
`ifdef PLL_LOCK_MONITOR_EN
        mon_cnt_d = 2'd0;
`endif

        accept_s    = cfg_valid && cfg_ready_q;
        timeout_s   = (timer_q == TMO_LAST);
        timer_inc_s = (timer_q == TMO_MAX) ? timer_q : timer_q + TMO_ONE;
        retry_inc_s = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_ONE;
        // The retry that exhausts the budget latches the fault instead of resetting again
        timeout_state_s = (retry_inc_s == RETRY_MAX) ? FAULT : RST_HOLD;

        case (state_q)
            RST_HOLD: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    timer_d = {TW{1'b0}};
                end else begin
                    rst_cnt_d = (rst_cnt_q == RST_MAX) ? rst_cnt_q : rst_cnt_q + RST_ONE;
                end
            end
            WAIT_LOCK: begin
                timer_d = timer_inc_s;
                if (timeout_s) begin
                    retry_d   = retry_inc_s;
                    state_d   = timeout_state_s;
                    rst_cnt_d = {RW{1'b0}};
                end else if (lock_s) begin
                    state_d  = SETTLE;
                    stable_d = {SW{1'b0}};
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            SETTLE: begin
                // Timer keeps running: the timeout bounds the whole attempt, not each settle try
                timer_d = timer_inc_s;
                if (timeout_s) begin
                    retry_d   = retry_inc_s;
                    state_d   = timeout_state_s;
                    rst_cnt_d = {RW{1'b0}};
                end else if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (stable_q == STABLE_LAST) begin
                    state_d = LOCKED;
                end else begin
                    stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + STABLE_ONE;
                end
            end
            LOCKED: begin
`ifdef PLL_LOCK_MONITOR_EN
                if (lock_s) begin
                    mon_cnt_d = 2'd0;
                end else if (mon_cnt_q == MON_LAST) begin
                    state_d   = RST_HOLD;
                    rst_cnt_d = {RW{1'b0}};
                    retry_d   = {NW{1'b0}};
                end else begin
                    mon_cnt_d = mon_cnt_q + MON_ONE;
                end
`else
                state_d = LOCKED;
`endif
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d   = RST_HOLD;
                rst_cnt_d = {RW{1'b0}};
            end
        endcase

        // cfg_ready is only high in LOCKED/FAULT, so accept overrides those states only
        if (accept_s) begin
            state_d   = RST_HOLD;
            rst_cnt_d = {RW{1'b0}};
            retry_d   = {NW{1'b0}};
            idsel_d   = cfg_idsel;
            fbdsel_d  = cfg_fbdsel;
            odsel_d   = cfg_odsel;
            psda_d    = cfg_psda;
            dutyda_d  = cfg_dutyda;
        end else begin
            idsel_d   = idsel_q;
            fbdsel_d  = fbdsel_q;
            odsel_d   = odsel_q;
            psda_d    = psda_q;
            dutyda_d  = dutyda_q;
        end

        // Outputs are decoded from the next state so they register alongside it
        pll_reset_d = st_pll_reset(state_d);
        busy_d      = st_busy(state_d);
        cfg_ready_d = !st_busy(state_d);
        clk_ok_d    = (state_d == LOCKED);
        err_d       = (state_d == FAULT);
    end

    // Sequencer state, counters, selectors and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_HOLD;
            rst_cnt_q   <= {RW{1'b0}};
            timer_q     <= {TW{1'b0}};
            stable_q    <= {SW{1'b0}};
            retry_q     <= {NW{1'b0}};
            idsel_q     <= DEF_IDSEL;
            fbdsel_q    <= DEF_FBDSEL;
            odsel_q     <= DEF_ODSEL;
            psda_q      <= PSDA_RST;
            dutyda_q    <= DUTYDA_RST;
            pll_reset_q <= 1'b1;
            cfg_ready_q <= 1'b0;
            clk_ok_q    <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
`ifdef PLL_LOCK_MONITOR_EN
            mon_cnt_q   <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            timer_q     <= timer_d;
            stable_q    <= stable_d;
            retry_q     <= retry_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
            psda_q      <= psda_d;
            dutyda_q    <= dutyda_d;
            pll_reset_q <= pll_reset_d;
            cfg_ready_q <= cfg_ready_d;
            clk_ok_q    <= clk_ok_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
`ifdef PLL_LOCK_MONITOR_EN
            mon_cnt_q   <= mon_cnt_d;
`endif
        end
    end

    assign pll_reset   = pll_reset_q;
    assign pll_reset_p = pll_reset_q;
    assign cfg_ready   = cfg_ready_q;
    assign clk_ok      = clk_ok_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign pll_idsel   = idsel_q;
    assign pll_fbdsel  = fbdsel_q;
    assign pll_odsel   = odsel_q;
    assign pll_psda    = psda_q;
    assign pll_dutyda  = dutyda_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Testbench for pll_reconfig_ctrl: directed scenarios, a cycle-level
// behavioural model compared every cycle, and hand-computed literal checks.
module tb_pll_reconfig_ctrl;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 64;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
    logic [3:0] cfg_psda, cfg_dutyda;
    logic       pll_reset, pll_reset_p;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [3:0] pll_psda, pll_dutyda;
    logic       pll_lock;
    logic       clk_ok, busy, err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pll_reconfig_ctrl #(
        .DEF_IDSEL     (6'd59),
        .DEF_FBDSEL    (6'd55),
        .DEF_ODSEL     (6'd60),
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_idsel   (cfg_idsel),
        .cfg_fbdsel  (cfg_fbdsel),
        .cfg_odsel   (cfg_odsel),
        .cfg_psda    (cfg_psda),
        .cfg_dutyda  (cfg_dutyda),
        .pll_reset   (pll_reset),
        .pll_reset_p (pll_reset_p),
        .pll_idsel   (pll_idsel),
        .pll_fbdsel  (pll_fbdsel),
        .pll_odsel   (pll_odsel),
        .pll_psda    (pll_psda),
        .pll_dutyda  (pll_dutyda),
        .pll_lock    (pll_lock),
        .clk_ok      (clk_ok),
        .busy        (busy),
        .err         (err)
    );

    // ---------------- behavioural model ----------------
    // hold_left: reset cycles still to serve; elapsed: cycles since release;
    // run: consecutive synced-high cycles while settling (-1 = not yet seen lock)
    int         m_hold, m_elapsed, m_run, m_tries, m_low;
    bit         m_locked, m_fault, m_s1, m_s2;
    logic [5:0] m_id, m_fb, m_od;
    logic [3:0] m_ps, m_du;

    task automatic model_reset();
        m_hold = RST_CYCLES; m_elapsed = 0; m_run = -1; m_tries = 0; m_low = 0;
        m_locked = 1'b0; m_fault = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
        m_id = 6'd59; m_fb = 6'd55; m_od = 6'd60; m_ps = 4'd0; m_du = 4'd8;
    endtask

    task automatic model_step();
        bit ls;
        if (!rst_n) begin
            model_reset();
        end else begin
            ls = m_s2; m_s2 = m_s1; m_s1 = pll_lock;
            if (cfg_valid && (m_locked || m_fault)) begin
                m_id = cfg_idsel; m_fb = cfg_fbdsel; m_od = cfg_odsel;
                m_ps = cfg_psda; m_du = cfg_dutyda;
                m_tries = 0; m_locked = 1'b0; m_fault = 1'b0; m_hold = RST_CYCLES;
            end else if (m_hold > 0) begin
                m_hold--; m_elapsed = 0; m_run = -1;
            end else if (m_fault) begin
                m_fault = 1'b1;
            end else if (m_locked) begin
`ifdef PLL_LOCK_MONITOR_EN
                m_low = ls ? 0 : m_low + 1;
                if (m_low == 2) begin
                    m_locked = 1'b0; m_tries = 0; m_hold = RST_CYCLES;
                end
`else
                m_locked = 1'b1;
`endif
            end else if (m_elapsed == LOCK_TIMEOUT - 1) begin
                m_tries++;
                if (m_tries == MAX_RETRIES) m_fault = 1'b1;
                else m_hold = RST_CYCLES;
            end else begin
                m_elapsed++;
                if (m_run < 0) begin
                    if (ls) m_run = 0;
                end else if (!ls) begin
                    m_run = -1;
                end else begin
                    m_run++;
                    if (m_run == STABLE_CYCLES) begin
                        m_locked = 1'b1; m_low = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic r;
        r = (m_hold > 0) || m_fault;
        return {m_locked || m_fault, r, r, m_id, m_fb, m_od, m_ps, m_du,
                m_locked, !(m_locked || m_fault), m_fault};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {cfg_ready, pll_reset, pll_reset_p, pll_idsel, pll_fbdsel, pll_odsel,
                pll_psda, pll_dutyda, clk_ok, busy, err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model steps on the rising edge, all outputs compared on the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("outputs_vs_model", dut_vec(), model_vec());
    endtask

    task automatic apply_cfg(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od,
                             input logic [3:0] ps, input logic [3:0] du);
        cfg_valid = 1'b1; cfg_idsel = id; cfg_fbdsel = fb; cfg_odsel = od;
        cfg_psda = ps; cfg_dutyda = du;
    endtask

    // Advance until pll_reset is low; bounded
    task automatic wait_reset_low(input string name);
        int k;
        k = 0;
        while (pll_reset !== 1'b0 && k < 200) begin tick(); k++; end
        if (pll_reset !== 1'b0) chk({name, "_timeout"}, 32'(pll_reset), 32'd0);
    endtask

    initial begin
        int falls, hi, n;
        bit prev, seen_drop, seen_rst;

        rst_n = 1'b0; cfg_valid = 1'b0; pll_lock = 1'b0;
        cfg_idsel = 6'd0; cfg_fbdsel = 6'd0; cfg_odsel = 6'd0; cfg_psda = 4'd0; cfg_dutyda = 4'd0;
        model_reset();
        repeat (3) tick();
        chk("rst_pll_reset", 32'(pll_reset), 32'd1);
        chk("rst_busy",      32'(busy),      32'd1);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_idsel",     32'(pll_idsel), 32'd59);
        chk("rst_dutyda",    32'(pll_dutyda), 32'd8);
        rst_n = 1'b1;

        // Lock never arrives: three reset pulses then fault
        falls = 0; hi = 0; prev = 1'b1; n = 0;
        while (err !== 1'b1 && n < 1000) begin
            tick(); n++;
            if (pll_reset) hi++;
            if (prev && !pll_reset) begin
                falls++;
                if (falls > 1) chk("retry_pulse_len", 32'(hi), 32'd4);
            end
            if (!prev && pll_reset) hi = 1;
            prev = pll_reset;
        end
        chk("fault_reached", 32'(err), 32'd1);
        repeat (10) begin
            tick();
            if (prev && !pll_reset) falls++;
            prev = pll_reset;
        end
        chk("fault_pulse_count", 32'(falls), 32'd3);
        chk("fault_flags", {28'd0, err, busy, cfg_ready, pll_reset}, 32'b1011);

        // Reconfigure from FAULT, then async reset in the middle of WAIT_LOCK
        apply_cfg(6'd10, 6'd20, 6'd30, 4'd5, 4'd3);
        tick();
        cfg_valid = 1'b0;
        chk("fault_accept_idsel", 32'(pll_idsel), 32'd10);
        chk("fault_accept_err",   32'(err),       32'd0);
        wait_reset_low("reconf_release");
        repeat (3) tick();
        @(posedge clk);
        model_step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_flags", {27'd0, pll_reset, pll_reset_p, busy, cfg_ready, clk_ok} , 32'b11100);
        chk("async_rst_err",   32'(err), 32'd0);
        chk("async_rst_sel",   {8'd0, pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda},
            {8'd0, 6'd59, 6'd55, 6'd60, 4'd0, 4'd8});
        @(negedge clk);
        chk("outputs_vs_model", dut_vec(), model_vec());
        tick(); tick();
        rst_n = 1'b1;

        // Power-on lock: pll_lock rises 10 cycles after pll_reset falls
        wait_reset_low("poweron_release");
        n = 0;
        repeat (10) begin tick(); n++; end
        pll_lock = 1'b1;
        while (clk_ok !== 1'b1 && n < 200) begin tick(); n++; end
        chk("poweron_clk_ok_not_early", 32'(n >= 20), 32'd1);
        chk("poweron_ready_err", {30'd0, cfg_ready, err}, 32'b10);

        // Reconfigure from LOCKED with idsel 58
        apply_cfg(6'd58, 6'd55, 6'd60, 4'd0, 4'd8);
        tick();
        cfg_valid = 1'b0;
        chk("reconf_idsel",  32'(pll_idsel), 32'd58);
        chk("reconf_clk_ok", 32'(clk_ok),    32'd0);
        hi = 0;
        while (pll_reset === 1'b1 && hi < 50) begin hi++; tick(); end
        chk("reconf_reset_len", 32'(hi), 32'd4);

        // cfg_valid while busy is ignored
        apply_cfg(6'd7, 6'd7, 6'd7, 4'd7, 4'd7);
        repeat (3) tick();
        cfg_valid = 1'b0;
        chk("busy_ignore_idsel", 32'(pll_idsel), 32'd58);
        n = 0;
        while (clk_ok !== 1'b1 && n < 200) begin tick(); n++; end
        chk("relock", 32'(clk_ok), 32'd1);

        // One-cycle lock dropout on the 5th settle cycle
        pll_lock = 1'b0;
        apply_cfg(6'd57, 6'd55, 6'd60, 4'd2, 4'd8);
        tick();
        cfg_valid = 1'b0;
        wait_reset_low("glitch_release");
        pll_lock = 1'b1;
        n = 0;
        while (clk_ok !== 1'b1 && n < 200) begin
            tick(); n++;
            if (n == 5) pll_lock = 1'b0;
            if (n == 6) pll_lock = 1'b1;
        end
        chk("glitch_relock_cycle", 32'(n), 32'd17);

        // Lock lost for 3 cycles while LOCKED
        pll_lock = 1'b0;
        seen_drop = 1'b0; seen_rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) pll_lock = 1'b1;
            tick();
            if (!clk_ok) seen_drop = 1'b1;
            if (pll_reset) seen_rst = 1'b1;
        end
`ifdef PLL_LOCK_MONITOR_EN
        chk("monitor_drop", {30'd0, seen_drop, seen_rst}, 32'b11);
`else
        chk("monitor_off_hold", {30'd0, seen_drop, seen_rst}, 32'b00);
        chk("monitor_off_clk_ok", 32'(clk_ok), 32'd1);
`endif
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
